// File: rtl/bcd3_display_scan.sv
// bcd3_display_scan
// Time-multiplexed 4-position seven-segment driver for a 3-digit packed BCD
// sum plus carry. A load strobe captures the sum into shadow registers; a
// prescaled scan counter walks the positions units, tens, hundreds,
// thousands. The thousands position shows the carry as "1". Leading zeros
// are blanked, and nibbles above 9 are flagged on err and drawn as "E".
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   load   in   capture strobe for s/cout
//   s      in   [11:0] packed BCD: [3:0] units, [7:4] tens, [11:8] hundreds
//   cout   in   carry-out of the BCD adder (thousands digit)
//   seg    out  [6:0] segments {g,f,e,d,c,b,a}, active-high, registered
//   an     out  [3:0] one-hot position enable, an[0] = units, registered
//   err    out  high while any captured nibble is above 9, registered
//   idx_dbg out [1:0] current scan position, for observation
//
// Handshake: load is a plain level-sampled strobe with no ready; every
// rising edge with load=1 overwrites the shadow value.
module bcd3_display_scan #(
  parameter int DIV = 4,
  parameter int CW  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] s,
  input  logic        cout,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        err,
  output logic [1:0]  idx_dbg
);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [11:0]   sv;
  logic          sc;
  logic          tick;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;
  logic          err_next;
  logic [3:0]    units, tens, hund;

  assign units   = sv[3:0];
  assign tens    = sv[7:4];
  assign hund    = sv[11:8];
  assign tick    = (cnt == CW'(DIV - 1));
  assign idx_dbg = idx;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'h3F;
      4'd1:    r = 7'h06;
      4'd2:    r = 7'h5B;
      4'd3:    r = 7'h4F;
      4'd4:    r = 7'h66;
      4'd5:    r = 7'h6D;
      4'd6:    r = 7'h7D;
      4'd7:    r = 7'h07;
      4'd8:    r = 7'h7F;
      4'd9:    r = 7'h6F;
      default: r = 7'h79;
    endcase
    return r;
  endfunction

  // Output pattern for the current position. A position is blank only
  // when it and every more significant digit are zero, so inner zeros show.
  always_comb begin
    seg_next = 7'h00;
    an_next  = 4'b0001 << idx;
    err_next = (units > 4'd9) | (tens > 4'd9) | (hund > 4'd9);
    case (idx)
      2'd0: seg_next = enc(units);
      2'd1: seg_next = (!sc && hund == 4'd0 && tens == 4'd0) ? 7'h00 : enc(tens);
      2'd2: seg_next = (!sc && hund == 4'd0) ? 7'h00 : enc(hund);
      2'd3: seg_next = sc ? 7'h06 : 7'h00;
      default: seg_next = 7'h00;
    endcase
  end

  // Prescaler and scan position; load never touches these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Shadow capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv <= 12'h000;
      sc <= 1'b0;
    end else if (load) begin
      sv <= s;
      sc <= cout;
    end
  end

  // Output register, computed from pre-edge idx/sv/sc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'h00;
      an  <= 4'b0000;
      err <= 1'b0;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      err <= err_next;
    end
  end

endmodule

// File: tb/tb_bcd3_display_scan.sv
module tb_bcd3_display_scan;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [11:0] s = 12'h000;
  logic        cout = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err;
  logic [1:0]  idx_dbg;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  bcd3_display_scan #(.DIV(DIV), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .s(s), .cout(cout),
    .seg(seg), .an(an), .err(err), .idx_dbg(idx_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Behavioural model: position comes from the number of edges since reset
  // release; blanking is "this digit and everything above it are zero".
  int         k;
  logic [11:0] m_sv;
  logic        m_sc;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_err;

  function automatic logic [6:0] digit_code(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d > 9) return 7'h79;
    return tbl[d];
  endfunction

  function automatic logic [6:0] model_seg(input int p, input logic [11:0] v, input logic c);
    int d [4];
    bit lead;
    d[0] = int'(v[3:0]);
    d[1] = int'(v[7:4]);
    d[2] = int'(v[11:8]);
    d[3] = c ? 1 : 0;
    lead = 1'b1;
    for (int j = p; j < 4; j++) if (d[j] != 0) lead = 1'b0;
    if (p > 0 && lead) return 7'h00;
    return digit_code(d[p]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= 0;
      m_sv    <= 12'h000;
      m_sc    <= 1'b0;
      exp_seg <= 7'h00;
      exp_an  <= 4'b0000;
      exp_err <= 1'b0;
    end else begin
      exp_an  <= 4'b0001 << ((k / DIV) % 4);
      exp_seg <= model_seg((k / DIV) % 4, m_sv, m_sc);
      exp_err <= (m_sv[3:0] > 9) || (m_sv[7:4] > 9) || (m_sv[11:8] > 9);
      if (load) begin
        m_sv <= s;
        m_sc <= cout;
      end
      k <= k + 1;
    end
  end

  // Position shown after the most recent edge, and the one the next edge shows.
  function automatic int cur_pos();
    return ((k - 1) / DIV) % 4;
  endfunction
  function automatic int next_pos();
    return (k / DIV) % 4;
  endfunction
  function automatic bit next_tick();
    return (k % DIV) == DIV - 1;
  endfunction

  // Scoreboard compare, every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
        bad++;
        $display("FAIL model k=%0d: seg=%h an=%b err=%b required seg=%h an=%b err=%b",
                 k, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
  end

  // Driver / literal-check tasks
  task automatic check_lit(input string name, input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic do_load(input logic [11:0] v, input logic c);
    load = 1'b1; s = v; cout = c;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Checks 8 edges of seg against a per-position literal table.
  task automatic check_scan(input string name, input logic [6:0] l0, input logic [6:0] l1,
                            input logic [6:0] l2, input logic [6:0] l3);
    logic [6:0] lit [4];
    lit = '{l0, l1, l2, l3};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_lit(name, seg, lit[cur_pos()]);
    end
  endtask

  task automatic wait_next(input int p, input bit t);
    int n;
    n = 0;
    while (!(next_pos() == p && next_tick() == t) && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) begin
      total++; bad++;
      $display("FAIL wait_pos: got timeout required pos %0d", p);
    end
  endtask

  initial begin
    logic [6:0] an_lit [8];
    logic [6:0] sg_lit [8];
    an_lit = '{7'h1, 7'h2, 7'h2, 7'h4, 7'h4, 7'h8, 7'h8, 7'h1};
    sg_lit = '{7'h4F, 7'h5B, 7'h5B, 7'h06, 7'h06, 7'h00, 7'h00, 7'h4F};

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_lit("reset_seg", seg, 7'h00);
    check_lit("reset_an", {3'b0, an}, 7'h00);
    check_lit("reset_err", {6'b0, err}, 7'h00);

    // 1: release, load 123 at the first edge
    rst_n = 1'b1;
    do_load(12'h123, 1'b0);
    check_lit("first_an", {3'b0, an}, 7'h01);
    check_lit("first_seg", seg, 7'h3F);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_lit("t1_an", {3'b0, an}, an_lit[i]);
      check_lit("t1_seg", seg, sg_lit[i]);
      check_lit("t1_err", {6'b0, err}, 7'h00);
    end

    // 2: 999 + carry
    do_load(12'h999, 1'b1);
    check_scan("t2_seg", 7'h6F, 7'h6F, 7'h6F, 7'h06);

    // 3: leading-zero blanking and inner zeros
    do_load(12'h005, 1'b0);
    check_scan("t3a_seg", 7'h6D, 7'h00, 7'h00, 7'h00);
    do_load(12'h100, 1'b0);
    check_scan("t3b_seg", 7'h3F, 7'h3F, 7'h06, 7'h00);

    // 4: invalid nibble
    do_load(12'h0A3, 1'b0);
    check_lit("t4_err_old", {6'b0, err}, 7'h00);
    @(negedge clk);
    check_lit("t4_err_new", {6'b0, err}, 7'h01);
    check_scan("t4_seg", 7'h4F, 7'h79, 7'h00, 7'h00);
    do_load(12'h003, 1'b0);
    check_lit("t4_err_hold", {6'b0, err}, 7'h01);
    @(negedge clk);
    check_lit("t4_err_clr", {6'b0, err}, 7'h00);

    // 5a: load at idx=2 off-tick; second hundreds cycle shows new digit
    wait_next(2, 1'b0);
    do_load(12'h123, 1'b0);
    @(negedge clk);
    check_lit("t5a_an", {3'b0, an}, 7'h04);
    check_lit("t5a_seg", seg, 7'h06);
    // 5b: load coincident with tick into idx 2
    wait_next(1, 1'b1);
    do_load(12'h456, 1'b0);
    @(negedge clk);
    check_lit("t5b_an", {3'b0, an}, 7'h04);
    check_lit("t5b_seg", seg, 7'h66);

    // 6: asynchronous reset mid-scan at idx 3 with 999 loaded
    do_load(12'h999, 1'b0);
    while (cur_pos() != 3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_lit("t6_seg", seg, 7'h00);
    check_lit("t6_an", {3'b0, an}, 7'h00);
    check_lit("t6_err", {6'b0, err}, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_lit("t6_first_an", {3'b0, an}, 7'h01);
    check_lit("t6_first_seg", seg, 7'h3F);
    check_scan("t6_seg_scan", 7'h3F, 7'h00, 7'h00, 7'h00);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end
endmodule

// File: doc/bcd3_display_scan.md
Name: bcd3_display_scan

Overview:
Time-multiplexed 4-position seven-segment driver that consumes the 12-bit packed BCD sum and carry-out produced by the 3-digit BCD adder. A load strobe captures the sum into shadow registers. A prescaled scan counter then cycles through the positions units, tens, hundreds, thousands. The thousands position shows the carry ("1") and leading zeros are blanked. Invalid BCD nibbles are flagged and shown as "E".

Parameters:
DIV, 4, scan prescaler: position advances once every DIV clocks. Legal range is DIV >= 1; DIV=1 advances every clock.
CW, 16, prescaler counter width. It must satisfy 2^CW >= DIV.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  capture strobe for s/cout, sampled on the rising edge
s  input  12  packed BCD value: s[3:0] units, s[7:4] tens, s[11:8] hundreds
cout  input  1  BCD adder carry-out (thousands digit, 0 or 1)
seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
an  output  4  position enable, one-hot, active-high, registered; an[0] is units
err  output  1  high while any captured nibble is greater than 9, registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - seg=7'h00, an=4'b0000, err=0.
  - Shadow value sv=12'h000, shadow carry sc=0.
  - Position index idx=0, prescaler cnt=0.
  - Reset takes effect immediately, including mid-scan or mid-load. Release is synchronous to the next rising edge.
- Prescaler: cnt counts 0..DIV-1 and wraps to 0. tick = (cnt==DIV-1).
- Scan: on a tick edge, idx <= idx+1 mod 4 (wrapping 3 -> 0); otherwise idx holds. A load never alters cnt or idx.
- Capture: on an edge with load=1, sv <= s and sc <= cout. With load=0 the shadow holds. Load may be held high continuously, in which case the shadow tracks the inputs every clock.
- Output register: every edge computes an, seg and err from the pre-edge idx, sv and sc.
  - an <= one-hot(idx).
  - seg <= pattern(idx).
  - err <= (sv[3:0]>9) | (sv[7:4]>9) | (sv[11:8]>9).
  - Latency: a load sampled at edge N becomes visible on seg/err at edge N+1.
  - The first edge after reset release drives an=0001 and seg=7'h3F.
- Digit encoding: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any nibble A-F encodes as 79 ("E"). Blank is 00.
- Position rules:
  - idx0: units, never blanked.
  - idx1: tens, blank iff sc=0, hundreds=0 and tens=0.
  - idx2: hundreds, blank iff sc=0 and hundreds=0.
  - idx3: seg=06 if sc=1, else blank.
- Blanking only zeroes seg; an still cycles through all four positions. An invalid nibble is nonzero and is therefore never blanked.
- Simultaneous load and tick: both take effect on the same edge. The next edge shows the new position with the new shadow value.

Test Plan:
1. DIV=2. Reset, release, load s=12'h123 cout=0 once, observe 8 positions -> an sequence 0001,0010,0100,1000 with each held 2 clocks; seg 4F,5B,06,00; err=0.
2. Load s=12'h999 cout=1 (sum of 999+999+cin=1) -> seg 6F,6F,6F,06 at an 0001,0010,0100,1000.
3. Load s=12'h005 cout=0 -> seg 6D at units; 00 at tens, hundreds and thousands while an keeps cycling. Then load s=12'h100 -> seg 3F,3F,06,00 (inner zeros shown).
4. Load s=12'h0A3 -> err=1 one clock after the load edge; seg 4F,79,00,00. Then load 12'h003 -> err returns to 0 one clock later.
5. Load asserted for one clock while idx=2 -> idx/an cadence unchanged, and the hundreds pattern updates on the next edge. Load coincident with a tick -> the new position shows the new value immediately.
6. Drop rst_n mid-scan at idx=3 with sv=12'h999 -> seg=00, an=0000, err=0 asynchronously. After release, without load -> an=0001, seg=3F, and the other positions are blank.
